// File: rtl/pipe_pkg.sv
// pipe_pkg -- definitions shared by the pipeline register chain.
//   PIPE_NOP_BIT     : fill bit of the default NOP/flush encoding (all zeros).
//   PIPE_DEF_WIDTH   : default payload width.
//   PIPE_NOP_PARITY  : even parity of the default NOP word.
//   occ_width()      : bits needed to count 0..depth occupied stages.
// Optional feature macro used by the chain: PIPE_REG_PARITY_EN.
package pipe_pkg;

  localparam logic PIPE_NOP_BIT    = 1'b0;
  localparam int   PIPE_DEF_WIDTH  = 64;
  localparam logic PIPE_NOP_PARITY = ^{PIPE_DEF_WIDTH{PIPE_NOP_BIT}};

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// pipe_stage -- one register stage of the pipeline chain.
// Holds a payload word, a valid bit and (with PIPE_REG_PARITY_EN defined)
// an even-parity bit. Flush wins over load; both reset and flush restore
// the NOP word and its parity.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         capture the inputs this edge (chain advance)
//   flush        synchronous clear to NOP / invalid
//   d_in, v_in, p_in     data, valid, parity from the previous stage
//   d_out, v_out, p_out  registered stage contents
module pipe_stage #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0,
  parameter logic             FLUSH_PAR = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             flush,
  input  logic [WIDTH-1:0] d_in,
  input  logic             v_in,
  input  logic             p_in,
  output logic [WIDTH-1:0] d_out,
  output logic             v_out,
  output logic             p_out
);

  // Payload is captured regardless of v_in: an invalid stage still carries data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_out <= FLUSH_VAL;
      v_out <= 1'b0;
    end else if (flush) begin
      d_out <= FLUSH_VAL;
      v_out <= 1'b0;
    end else if (load) begin
      d_out <= d_in;
      v_out <= v_in;
    end
  end

`ifdef PIPE_REG_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_out <= FLUSH_PAR;
    end else if (flush) begin
      p_out <= FLUSH_PAR;
    end else if (load) begin
      p_out <= p_in;
    end
  end
`else
  // No parity storage: the stage reports the NOP parity as a constant.
  logic unused_p_in;
  assign unused_p_in = p_in;
  assign p_out       = FLUSH_PAR;
`endif

endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain -- parametrised pipeline register chain.
// A WIDTH-bit payload with a valid bit shifts through DEPTH stages while en
// is high; en low stalls every stage; flush (higher priority) clears all
// stages to FLUSH_VAL/invalid. occupancy counts valid stages incrementally.
// Optional macro PIPE_REG_PARITY_EN: each stage carries an even-parity bit
// and parity_err flags a mismatch on a valid output; otherwise parity_err
// is tied low and parity_inj is ignored.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   en             advance enable (0 = stall)
//   flush          synchronous flush, wins over en
//   in_valid       data_in carries a real item
//   data_in        payload into stage 0
//   parity_inj     test-only: invert the parity captured at stage 0
//   out_valid      valid bit of the last stage
//   data_out       data of the last stage
//   occupancy      number of valid stages
//   parity_err     parity mismatch on a valid output
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = PIPE_DEF_WIDTH,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] FLUSH_VAL = {WIDTH{PIPE_NOP_BIT}}
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         parity_inj,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             data_out,
  output logic [occ_width(DEPTH)-1:0]  occupancy,
  output logic                         parity_err
);

  localparam int   OCC_W     = occ_width(DEPTH);
  localparam logic FLUSH_PAR = ^FLUSH_VAL;

  logic [WIDTH-1:0] din_p  [DEPTH];
  logic             vin_p  [DEPTH];
  logic             pin_p  [DEPTH];
  logic [WIDTH-1:0] data_p [DEPTH];
  logic             vld_p  [DEPTH];
  logic             par_p  [DEPTH];
  logic [OCC_W-1:0] occ_q;

  // Stage 0 takes the chain inputs; parity_inj deliberately corrupts parity.
  assign din_p[0] = data_in;
  assign vin_p[0] = in_valid;
  assign pin_p[0] = (^data_in) ^ parity_inj;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k > 0) begin : g_link
      assign din_p[k] = data_p[k-1];
      assign vin_p[k] = vld_p[k-1];
      assign pin_p[k] = par_p[k-1];
    end
    pipe_stage #(
      .WIDTH     (WIDTH),
      .FLUSH_VAL (FLUSH_VAL),
      .FLUSH_PAR (FLUSH_PAR)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (en),
      .flush (flush),
      .d_in  (din_p[k]),
      .v_in  (vin_p[k]),
      .p_in  (pin_p[k]),
      .d_out (data_p[k]),
      .v_out (vld_p[k]),
      .p_out (par_p[k])
    );
  end

  // Occupancy tracks the shift: the new item enters as the oldest one leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else if (flush) begin
      occ_q <= '0;
    end else if (en) begin
      occ_q <= occ_q + OCC_W'(in_valid) - OCC_W'(vld_p[DEPTH-1]);
    end
  end

  assign out_valid = vld_p[DEPTH-1];
  assign data_out  = data_p[DEPTH-1];
  assign occupancy = occ_q;

`ifdef PIPE_REG_PARITY_EN
  assign parity_err = out_valid & ((^data_out) != par_p[DEPTH-1]);
`else
  logic unused_par_last;
  assign unused_par_last = par_p[DEPTH-1];
  assign parity_err      = 1'b0;
`endif

endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
- Parametrised pipeline register chain that generalises the 2-bit enable register.
- WIDTH-bit payload travels through DEPTH stages, each with a valid bit.
- Global stall (en low), synchronous flush inserting bubbles, and an occupancy count.
- Sits between pipelined-datapath stages (IF/ID, ID/EX, EX/MEM) and replaces the fixed-width stage registers.

Parameters:
- WIDTH, 64: payload width in bits, at least 1.
- DEPTH, 1: number of register stages, at least 1.
- FLUSH_VAL, {WIDTH{1'b0}}: data value loaded on reset and on flush (the NOP encoding).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  advance enable; 0 stalls the whole chain.
- flush  in  1  synchronous flush; clears every stage.
- in_valid  in  1  data_in carries a real item.
- data_in  in  WIDTH  payload into stage 0.
- parity_inj  in  1  test-only; inverts the parity bit captured at stage 0.
- out_valid  out  1  valid bit of stage DEPTH-1.
- data_out  out  WIDTH  data of stage DEPTH-1.
- occupancy  out  $clog2(DEPTH+1)  number of stages whose valid bit is 1.
- parity_err  out  1  parity mismatch on a valid output.

Behaviour:
- Interface is fixed: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, at any time including mid-operation):
  - Immediately, with no clock edge: all stage data = FLUSH_VAL, all valid = 0, occupancy = 0, parity_err = 0.
  - Release is synchronous to the next clk edge; no update occurs on the edge where rst_n is still 0.
- Priority at each clk edge: flush, then en.
- flush=1 (en ignored):
  - All valid <= 0, all data <= FLUSH_VAL, occupancy <= 0.
  - data_in and in_valid in the same cycle are discarded.
- flush=0, en=1:
  - Stage 0 <= {data_in, in_valid}.
  - Stage k <= stage k-1 for k = 1..DEPTH-1.
  - The item in stage DEPTH-1 is dropped; there is no backpressure.
- flush=0, en=0: every stage holds, including its valid bit; data_in is ignored.
- Data is captured whether or not in_valid is set; an invalid stage still carries data, matching the enable-register behaviour.
- Latency: an item appears on data_out/out_valid after exactly DEPTH clk edges with en=1. Stalled cycles add 1:1.
- Outputs come straight from the last stage's registers; there is no combinational path from the inputs.
- occupancy:
  - Registered counter, updated incrementally each cycle by +in_valid − out_valid when shifting.
  - Must equal the popcount of the valid bits after every edge.
  - Saturation is impossible: the maximum value is DEPTH.
- DEPTH=1 degenerates to a single enable register plus a valid bit.

Optional Feature:
- Macro: PIPE_REG_PARITY_EN.
- Defined:
  - Each stage carries one extra even-parity bit, computed at stage 0 as ^data_in XOR parity_inj.
  - It shifts, holds, flushes (to the parity of FLUSH_VAL) and resets (also to the parity of FLUSH_VAL) exactly like the data.
  - parity_err = out_valid & (^data_out != stored parity bit), combinational from the last-stage registers.
- Not defined:
  - No parity storage.
  - parity_err tied to 0; parity_inj is ignored.
  - Port list is unchanged.

Decomposition:
- Shared package pipe_pkg holds:
  - the NOP/FLUSH default constant;
  - the function for occupancy width, clog2(DEPTH+1);
  - a localparam computing the FLUSH_VAL parity.
- One sub-module, pipe_stage: a single stage with data, valid and optional parity, async reset, and inputs for load-enable and flush.
- The top level generates DEPTH instances and the occupancy counter.

Test Plan (WIDTH=8, DEPTH=3, FLUSH_VAL=8'h00):
- Reset: hold rst_n=0 with en=1 and data_in=8'hA5 toggling for 4 cycles -> out_valid=0, data_out=8'h00, occupancy=0. Assert rst_n=0 mid-stream while occupancy=3 -> all zero before the next clk edge.
- Streaming: en=1, inputs 8'h11, 8'h22, 8'h33 valid on consecutive cycles -> 8'h11 appears with out_valid=1 on the 3rd edge after its input, then 8'h22, then 8'h33. occupancy goes 1,2,3, holds 3, then falls to 0 after 3 idle cycles.
- Stall: after loading 8'h11 and 8'h22, hold en=0 for 5 cycles with data_in=8'hFF valid -> all stages, outputs and occupancy frozen. Resume -> 8'h11 exits 5 cycles later than in the streaming case, and 8'hFF is never captured.
- Flush priority: pipeline full, assert flush=1 and en=1 with data_in=8'h44 valid -> next edge gives occupancy=0, out_valid=0, data_out=8'h00, and 8'h44 never emerges. Same result with en=0.
- Bubbles: in_valid pattern 1,0,1 with data 8'h01, 8'h02, 8'h03 -> out_valid pattern 1,0,1 and data_out 8'h01, 8'h02, 8'h03 (data passes even when invalid). occupancy stays at most 2.
- Parity (PIPE_REG_PARITY_EN defined):
  - data_in=8'h07 with parity_inj=1 -> parity_err=1 exactly while that item is on the output with out_valid=1.
  - parity_inj=0 -> parity_err=0 always.
  - Without the macro -> parity_err constant 0.
